// File: rtl/control_pkg.sv
// control_pkg: shared types and opcode helpers for the multi-cycle control
// sequencer. Opcode values are derived from the opcode width so that any
// OPW keeps the same layout: the three highest codes are BR, STORE and LOAD,
// and every lower code is an ALU operation.
package control_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        MEMWAIT = 3'd3,
        HALT    = 3'd4
    } state_t;

    // Low six IR bits of a BR instruction that mark it as HALT.
    localparam logic [5:0] HALT_FIELD = 6'b000000;

    function automatic int op_br_code(input int opw);
        return (32'sd1 <<< opw) - 32'sd1;
    endfunction

    function automatic int op_store_code(input int opw);
        return op_br_code(opw) - 32'sd1;
    endfunction

    function automatic int op_load_code(input int opw);
        return op_br_code(opw) - 32'sd2;
    endfunction

    // Opcode constants for the default 3-bit opcode width.
    localparam int          DEF_OPW  = 3;
    localparam logic [2:0]  OP_BR    = 3'(op_br_code(DEF_OPW));
    localparam logic [2:0]  OP_STORE = 3'(op_store_code(DEF_OPW));
    localparam logic [2:0]  OP_LOAD  = 3'(op_load_code(DEF_OPW));

endpackage

// File: rtl/control_seq.sv
// control_seq: multi-cycle control sequencer.
// Latches the fetched instruction into IR and steps it through
// IDLE -> FETCH -> EXEC (-> MEMWAIT) -> FETCH ..., ending in HALT.
// Ports:
//   Clk       clock, rising edge
//   Reset     synchronous, active-high; also forces all outputs low
//   Start     begin execution (only looked at in IDLE)
//   instr     instruction ROM output at the current PC
//   pc_en     one pulse per retired instruction (advance/branch PC)
//   Branch    branch in execute; how_high = IR[4:3] target selector
//   RegWrite  reg_file write strobe; MemtoReg selects memory data
//   MemWrite  data memory write strobe
//   ALUSrc    tied 0;  RegDst tied 0
//   ALUOp     ALU operation select (opcode of an ALU instruction)
//   Done      held high in HALT
module control_seq
    import control_pkg::*;
#(
    parameter int OPW       = 3,
    parameter int MCODEBITS = 9,
    parameter int MEM_LAT   = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [MCODEBITS-1:0] instr,
    output logic                 pc_en,
    output logic                 Branch,
    output logic [1:0]           how_high,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic                 RegDst,
    output logic [OPW-1:0]       ALUOp,
    output logic                 Done
);

    localparam logic [OPW-1:0] OP_BR_C    = OPW'(op_br_code(OPW));
    localparam logic [OPW-1:0] OP_STORE_C = OPW'(op_store_code(OPW));
    localparam logic [OPW-1:0] OP_LOAD_C  = OPW'(op_load_code(OPW));
    // Counter preload: EXEC already spends one load cycle, so MEMWAIT
    // lasts MEM_LAT cycles ending on the cycle the counter reads zero.
    localparam logic [3:0]     LAT_M1     = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t                r_state;
    state_t                w_next_state;
    logic [MCODEBITS-1:0]  r_ir;
    logic [3:0]            r_wait_cnt;
    logic [3:0]            w_wait_cnt_next;
    logic [OPW-1:0]        w_opcode;
    logic [5:0]            w_low;

    assign w_opcode = r_ir[MCODEBITS-1 -: OPW];
    assign w_low    = r_ir[5:0];

    // State, instruction register and load wait counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_ir       <= '0;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_state == FETCH) begin
                r_ir <= instr;
            end else begin
                r_ir <= r_ir;
            end
        end
    end

    // Next-state, counter and output decode from state and IR.
    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        pc_en           = 1'b0;
        Branch          = 1'b0;
        how_high        = 2'b00;
        RegWrite        = 1'b0;
        MemWrite        = 1'b0;
        MemtoReg        = 1'b0;
        ALUSrc          = 1'b0;
        RegDst          = 1'b0;
        ALUOp           = {OPW{1'b0}};
        Done            = 1'b0;

        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                w_next_state = EXEC;
            end
            EXEC: begin
                if (w_opcode == OP_BR_C) begin
                    if (w_low == HALT_FIELD) begin
                        w_next_state = HALT;
                    end else begin
                        Branch       = 1'b1;
                        how_high     = r_ir[4:3];
                        pc_en        = 1'b1;
                        w_next_state = FETCH;
                    end
                end else if (w_opcode == OP_STORE_C) begin
                    MemWrite     = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = FETCH;
                end else if (w_opcode == OP_LOAD_C) begin
                    MemtoReg = 1'b1;
                    if (MEM_LAT == 0) begin
                        RegWrite     = 1'b1;
                        pc_en        = 1'b1;
                        w_next_state = FETCH;
                    end else begin
                        w_wait_cnt_next = LAT_M1;
                        w_next_state    = MEMWAIT;
                    end
                end else begin
                    ALUOp        = w_opcode;
                    RegWrite     = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = FETCH;
                end
            end
            MEMWAIT: begin
                MemtoReg = 1'b1;
                if (r_wait_cnt == 4'd0) begin
                    RegWrite     = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = FETCH;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                    w_next_state    = MEMWAIT;
                end
            end
            HALT: begin
                Done         = 1'b1;
                w_next_state = HALT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Reset wins over everything so no write can land in the reset cycle.
        if (Reset) begin
            pc_en    = 1'b0;
            Branch   = 1'b0;
            how_high = 2'b00;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemtoReg = 1'b0;
            ALUOp    = {OPW{1'b0}};
            Done     = 1'b0;
        end else begin
            Done     = Done;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq. Two instances: A (OPW=3, MCODEBITS=9, MEM_LAT=2)
// and B (OPW=4, MCODEBITS=10, MEM_LAT=0). A ROM + PC model feeds instr; the
// expected output word for each cycle of an instruction is computed from
// the instruction's class and cycle index.
module tb_control_seq;

    logic        clk = 1'b0;
    logic        rst_a, start_a, rst_b, start_b;
    logic [8:0]  instr_a;
    logic [9:0]  instr_b;
    logic        pc_en_a, br_a, rw_a, mw_a, m2r_a, als_a, rd_a, done_a;
    logic        pc_en_b, br_b, rw_b, mw_b, m2r_b, als_b, rd_b, done_b;
    logic [1:0]  hh_a, hh_b;
    logic [2:0]  aop_a;
    logic [3:0]  aop_b;
    logic [13:0] w_obs_a, w_obs_b;

    logic [9:0]  rom [0:63];
    int          n_checks = 0;
    int          n_err    = 0;

    always #5 clk = ~clk;

    control_seq #(.OPW(3), .MCODEBITS(9), .MEM_LAT(2)) u_a (
        .Clk(clk), .Reset(rst_a), .Start(start_a), .instr(instr_a),
        .pc_en(pc_en_a), .Branch(br_a), .how_high(hh_a), .RegWrite(rw_a),
        .MemWrite(mw_a), .MemtoReg(m2r_a), .ALUSrc(als_a), .RegDst(rd_a),
        .ALUOp(aop_a), .Done(done_a)
    );

    control_seq #(.OPW(4), .MCODEBITS(10), .MEM_LAT(0)) u_b (
        .Clk(clk), .Reset(rst_b), .Start(start_b), .instr(instr_b),
        .pc_en(pc_en_b), .Branch(br_b), .how_high(hh_b), .RegWrite(rw_b),
        .MemWrite(mw_b), .MemtoReg(m2r_b), .ALUSrc(als_b), .RegDst(rd_b),
        .ALUOp(aop_b), .Done(done_b)
    );

    assign w_obs_a = {pc_en_a, br_a, hh_a, rw_a, mw_a, m2r_a, als_a, rd_a, done_a, 1'b0, aop_a};
    assign w_obs_b = {pc_en_b, br_b, hh_b, rw_b, mw_b, m2r_b, als_b, rd_b, done_b, aop_b};

    // Expected output word for cycle k of an instruction (k=0 is its fetch
    // cycle). Packing: {pc_en, Branch, how_high, RegWrite, MemWrite,
    // MemtoReg, ALUSrc, RegDst, Done, ALUOp[3:0]}.
    function automatic logic [13:0] exp_word(input int opw, input int lat,
                                             input logic [9:0] ins, input int k);
        int         top = (1 << opw) - 1;
        int         op  = int'(ins >> 6);
        logic       pce = 1'b0, br = 1'b0, rw = 1'b0, mw = 1'b0, m2r = 1'b0, dn = 1'b0;
        logic [1:0] hh  = 2'b00;
        logic [3:0] aop = 4'd0;
        if (k >= 1) begin
            if (op == top) begin
                if (ins[5:0] != 6'd0) begin
                    if (k == 1) begin br = 1'b1; hh = ins[4:3]; pce = 1'b1; end
                end else if (k >= 2) begin
                    dn = 1'b1;
                end
            end else if (op == top - 1) begin
                if (k == 1) begin mw = 1'b1; pce = 1'b1; end
            end else if (op == top - 2) begin
                if (k <= 1 + lat) m2r = 1'b1;
                if (k == 1 + lat) begin rw = 1'b1; pce = 1'b1; end
            end else if (k == 1) begin
                rw = 1'b1; pce = 1'b1; aop = 4'(op);
            end
        end
        return {pce, br, hh, rw, mw, m2r, 1'b0, 1'b0, dn, aop};
    endfunction

    function automatic logic [9:0] rand_instr(input int opw);
        int         top  = (1 << opw) - 1;
        int         kind = int'($urandom_range(0, 3));
        int         op;
        logic [5:0] low  = 6'($urandom);
        case (kind)
            0:       begin op = top; if (low == 6'd0) low = 6'd1; end
            1:       op = top - 1;
            2:       op = top - 2;
            default: op = int'($urandom_range(0, top - 3));
        endcase
        return 10'((op << 6) | int'(low));
    endfunction

    function automatic logic [13:0] get_obs(input int sel);
        return (sel == 0) ? w_obs_a : w_obs_b;
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic rst, input logic st);
        if (sel == 0) begin rst_a = rst; start_a = st; end
        else          begin rst_b = rst; start_b = st; end
    endtask

    task automatic set_instr(input int sel, input logic [9:0] v);
        if (sel == 0) instr_a = v[8:0];
        else          instr_b = v;
    endtask

    task automatic do_reset(input int sel);
        set_in(sel, 1'b1, 1'b0);
        tick();
        chk($sformatf("d%0d_reset", sel), get_obs(sel), 14'd0);
        set_in(sel, 1'b0, 1'b0);
        tick();
        chk($sformatf("d%0d_idle", sel), get_obs(sel), 14'd0);
    endtask

    // Runs rom[0..] from IDLE until the HALT instruction, then checks Done
    // for 10 cycles with Start pulsed. Start toggles randomly throughout.
    task automatic run_prog(input int sel);
        int         pc  = 0;
        int         opw = (sel == 0) ? 3 : 4;
        int         lat = (sel == 0) ? 2 : 0;
        int         top = (1 << opw) - 1;
        int         len;
        bit         halt = 1'b0;
        logic [9:0] ins;
        set_instr(sel, rom[0]);
        set_in(sel, 1'b0, 1'b1);
        tick();
        set_in(sel, 1'b0, 1'b0);
        while (!halt && pc < 64) begin
            ins  = rom[pc];
            halt = (int'(ins >> 6) == top) && (ins[5:0] == 6'd0);
            len  = (int'(ins >> 6) == top - 2) ? 2 + lat : 2;
            for (int k = 0; k < len; k++) begin
                chk($sformatf("d%0d_pc%0d_k%0d", sel, pc, k), get_obs(sel),
                    exp_word(opw, lat, ins, k));
                set_in(sel, 1'b0, 1'($urandom_range(0, 1)));
                tick();
            end
            if (halt) begin
                for (int c = 0; c < 10; c++) begin
                    chk($sformatf("d%0d_halt_c%0d", sel, c), get_obs(sel),
                        exp_word(opw, lat, ins, 2 + c));
                    set_in(sel, 1'b0, c[0]);
                    tick();
                end
                set_in(sel, 1'b0, 1'b0);
            end else begin
                pc++;
                set_instr(sel, rom[pc & 63]);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; instr_a = 9'd0;
        rst_b = 1'b1; start_b = 1'b0; instr_b = 10'd0;

        // Instance A: directed program ADD, STORE, LOAD, BR, HALT.
        do_reset(0);
        rom[0] = 10'b0_000_101010;
        rom[1] = 10'b0_110_000000;
        rom[2] = 10'b0_101_000000;
        rom[3] = 10'b0_111_011000;
        rom[4] = 10'b0_111_000000;
        run_prog(0);

        // Instance A: reset on the last MEMWAIT cycle of a load.
        do_reset(0);
        rom[0] = 10'b0_101_000111;
        set_instr(0, rom[0]);
        set_in(0, 1'b0, 1'b1);
        tick();
        set_in(0, 1'b0, 1'b0);
        chk("rstload_fetch", w_obs_a, exp_word(3, 2, rom[0], 0));
        tick();
        chk("rstload_exec", w_obs_a, exp_word(3, 2, rom[0], 1));
        tick();
        chk("rstload_wait1", w_obs_a, exp_word(3, 2, rom[0], 2));
        tick();
        set_in(0, 1'b1, 1'b0);
        #1;
        chk("rstload_last", w_obs_a, 14'd0);
        tick();
        set_in(0, 1'b0, 1'b0);
        #1;
        chk("rstload_idle", w_obs_a, 14'd0);
        tick();
        chk("rstload_idle2", w_obs_a, 14'd0);

        // Instance A: random program (leading LOAD) ending in HALT.
        rom[0] = 10'b0_101_010101;
        for (int i = 1; i < 25; i++) rom[i] = rand_instr(3);
        rom[25] = 10'b0_111_000000;
        run_prog(0);
        rst_a = 1'b1;

        // Instance B: wider opcode, zero load latency.
        do_reset(1);
        rom[0] = 10'b1100_110011;
        rom[1] = 10'b1101_000000;
        rom[2] = 10'b1111_010110;
        rom[3] = 10'b1011_111111;
        for (int i = 4; i < 24; i++) rom[i] = rand_instr(4);
        rom[24] = 10'b1111_000000;
        run_prog(1);
        rst_b = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
